// File: rtl/avr_decode_stage.sv
// Registered, handshaked AVR decode stage; folds two-word instructions into one packet.
// Optional macro AVR_DECODE_ILLEGAL_EN adds out_illegal for encodings outside the id table.
module avr_decode_stage #(
    parameter int PC_WIDTH  = 16,
    parameter int ID_WIDTH  = 8,
    parameter int ARG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [15:0]          in_word,
    input  logic [PC_WIDTH-1:0]  in_pc,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ID_WIDTH-1:0]  out_id,
    output logic [ARG_WIDTH-1:0] out_arg1,
    output logic [ARG_WIDTH-1:0] out_arg2,
    output logic [15:0]          out_ext,
    output logic [PC_WIDTH-1:0]  out_pc
`ifdef AVR_DECODE_ILLEGAL_EN
    ,
    output logic                 out_illegal
`endif
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT2 = 1'b1} state_t;

    state_t                state_q, state_d;
    logic                  out_valid_q, out_valid_d;
    logic [ID_WIDTH-1:0]   out_id_q, out_id_d;
    logic [ARG_WIDTH-1:0]  out_arg1_q, out_arg1_d, out_arg2_q, out_arg2_d;
    logic [15:0]           out_ext_q, out_ext_d;
    logic [PC_WIDTH-1:0]   out_pc_q, out_pc_d;
    logic [15:0]           held_word_q, held_word_d;
    logic [PC_WIDTH-1:0]   held_pc_q, held_pc_d;
`ifdef AVR_DECODE_ILLEGAL_EN
    logic                  out_illegal_q, out_illegal_d;
    logic                  dec_ill;
`endif

    logic                  accept;
    logic [15:0]           dec_word;
    logic [7:0]            dec_id;
    logic [ARG_WIDTH-1:0]  dec_a1, dec_a2;
    logic                  dec_two;
    logic [ARG_WIDTH-1:0]  rd_arg, rr_arg, imm_d, imm_k, io_a, br_k, long_k, rel_lo, rel_hi, one_arg;

    assign in_ready = !flush && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // In WAIT2 the opcode being completed is the held word, never the incoming operand.
    assign dec_word = (state_q == S_WAIT2) ? held_word_q : in_word;

    assign rd_arg  = ARG_WIDTH'(dec_word[8:4]);
    assign rr_arg  = ARG_WIDTH'({dec_word[9], dec_word[3:0]});
    assign imm_d   = ARG_WIDTH'({1'b1, dec_word[7:4]});
    assign imm_k   = ARG_WIDTH'({dec_word[11:8], dec_word[3:0]});
    assign io_a    = ARG_WIDTH'({dec_word[10:9], dec_word[3:0]});
    assign br_k    = {{(ARG_WIDTH-7){dec_word[9]}}, dec_word[9:3]};
    assign long_k  = ARG_WIDTH'({dec_word[8:4], dec_word[0]});
    assign rel_lo  = ARG_WIDTH'(dec_word[7:0]);
    assign rel_hi  = ARG_WIDTH'(dec_word[11:8]);
    assign one_arg = {{(ARG_WIDTH-1){1'b0}}, 1'b1};

    // Opcode decode: id, arguments and two-word flag for the current opcode word.
    always_comb begin
        dec_id  = 8'h00;
        dec_a1  = '0;
        dec_a2  = '0;
        dec_two = 1'b0;
`ifdef AVR_DECODE_ILLEGAL_EN
        dec_ill = 1'b0;
`endif
        casez (dec_word)
            16'b0000_0000_0000_0000: dec_id = 8'h00;
            16'b0001_11??_????_????: begin dec_id = 8'h01; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b0000_11??_????_????: begin dec_id = 8'h02; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b0010_00??_????_????: begin dec_id = 8'h03; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b1111_01??_????_?000: begin dec_id = 8'h04; dec_a1 = br_k; end
            16'b1111_00??_????_?000: begin dec_id = 8'h05; dec_a1 = br_k; end
            16'b1111_00??_????_?001: begin dec_id = 8'h06; dec_a1 = br_k; end
            16'b1111_01??_????_?001: begin dec_id = 8'h08; dec_a1 = br_k; end
            16'b1001_010?_????_111?: begin dec_id = 8'h09; dec_a1 = long_k; dec_two = 1'b1; end
            16'b1001_0100_1111_1000: dec_id = 8'h0A;
            16'b0001_01??_????_????: begin dec_id = 8'h0C; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b0011_????_????_????: begin dec_id = 8'h0D; dec_a1 = imm_d; dec_a2 = imm_k; end
            16'b0001_00??_????_????: begin dec_id = 8'h0E; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b1001_010?_????_1010: begin dec_id = 8'h0F; dec_a1 = rd_arg; dec_a2 = one_arg; end
            16'b0010_01??_????_????: begin dec_id = 8'h10; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b1011_0???_????_????: begin dec_id = 8'h11; dec_a1 = rd_arg; dec_a2 = io_a; end
            16'b1001_010?_????_0011: begin dec_id = 8'h12; dec_a1 = rd_arg; dec_a2 = one_arg; end
            16'b1001_010?_????_110?: begin dec_id = 8'h13; dec_a1 = long_k; dec_two = 1'b1; end
            16'b1110_????_????_????: begin dec_id = 8'h20; dec_a1 = imm_d; dec_a2 = imm_k; end
            16'b1001_000?_????_0000: begin dec_id = 8'h21; dec_a1 = rd_arg; dec_two = 1'b1; end
            16'b1001_010?_????_0110: begin dec_id = 8'h24; dec_a1 = rd_arg; end
            16'b0010_11??_????_????: begin dec_id = 8'h25; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b1001_11??_????_????: begin dec_id = 8'h26; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b0010_10??_????_????: begin dec_id = 8'h27; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b0110_????_????_????: begin dec_id = 8'h28; dec_a1 = imm_d; dec_a2 = imm_k; end
            16'b1011_1???_????_????: begin dec_id = 8'h29; dec_a1 = rd_arg; dec_a2 = io_a; end
            16'b1001_000?_????_1111: begin dec_id = 8'h2A; dec_a1 = rd_arg; dec_a2 = one_arg; end
            16'b1001_001?_????_1111: begin dec_id = 8'h2B; dec_a1 = rd_arg; dec_a2 = one_arg; end
            16'b1101_????_????_????: begin dec_id = 8'h2C; dec_a1 = rel_lo; dec_a2 = rel_hi; end
            16'b1001_0101_0000_1000: dec_id = 8'h2D;
            16'b1001_0101_0001_1000: dec_id = 8'h2E;
            16'b1100_????_????_????: begin dec_id = 8'h2F; dec_a1 = rel_lo; dec_a2 = rel_hi; end
            16'b1001_010?_????_0111: begin dec_id = 8'h31; dec_a1 = rd_arg; end
            16'b1001_0100_0111_1000: dec_id = 8'h32;
            16'b1001_001?_????_0000: begin dec_id = 8'h3F; dec_a1 = rd_arg; dec_two = 1'b1; end
            16'b0001_10??_????_????: begin dec_id = 8'h40; dec_a1 = rd_arg; dec_a2 = rr_arg; end
            16'b0101_????_????_????: begin dec_id = 8'h41; dec_a1 = imm_d; dec_a2 = imm_k; end
            default: begin
                dec_id = 8'h00;
`ifdef AVR_DECODE_ILLEGAL_EN
                dec_ill = 1'b1;
`endif
            end
        endcase
    end

    // Next-state: flush wins, then consumption, then word acceptance.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_id_d    = out_id_q;
        out_arg1_d  = out_arg1_q;
        out_arg2_d  = out_arg2_q;
        out_ext_d   = out_ext_q;
        out_pc_d    = out_pc_q;
        held_word_d = held_word_q;
        held_pc_d   = held_pc_q;
`ifdef AVR_DECODE_ILLEGAL_EN
        out_illegal_d = out_illegal_q;
`endif
        if (flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_id_d    = '0;
            out_arg1_d  = '0;
            out_arg2_d  = '0;
            out_ext_d   = 16'h0000;
            out_pc_d    = '0;
            held_word_d = 16'h0000;
            held_pc_d   = '0;
`ifdef AVR_DECODE_ILLEGAL_EN
            out_illegal_d = 1'b0;
`endif
        end else begin
            if (out_ready) begin
                out_valid_d = 1'b0;
            end else begin
                out_valid_d = out_valid_q;
            end
            if (accept) begin
                case (state_q)
                    S_IDLE: begin
                        if (dec_two) begin
                            held_word_d = in_word;
                            held_pc_d   = in_pc;
                            state_d     = S_WAIT2;
                        end else begin
                            out_valid_d = 1'b1;
                            out_id_d    = ID_WIDTH'(dec_id);
                            out_arg1_d  = dec_a1;
                            out_arg2_d  = dec_a2;
                            out_ext_d   = 16'h0000;
                            out_pc_d    = in_pc;
`ifdef AVR_DECODE_ILLEGAL_EN
                            out_illegal_d = dec_ill;
`endif
                        end
                    end
                    S_WAIT2: begin
                        out_valid_d = 1'b1;
                        out_id_d    = ID_WIDTH'(dec_id);
                        out_arg1_d  = dec_a1;
                        out_arg2_d  = dec_a2;
                        out_ext_d   = in_word;
                        out_pc_d    = held_pc_q;
                        state_d     = S_IDLE;
`ifdef AVR_DECODE_ILLEGAL_EN
                        out_illegal_d = 1'b0;
`endif
                    end
                    default: state_d = S_IDLE;
                endcase
            end else begin
                state_d = state_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_id_q    <= '0;
            out_arg1_q  <= '0;
            out_arg2_q  <= '0;
            out_ext_q   <= 16'h0000;
            out_pc_q    <= '0;
            held_word_q <= 16'h0000;
            held_pc_q   <= '0;
`ifdef AVR_DECODE_ILLEGAL_EN
            out_illegal_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_id_q    <= out_id_d;
            out_arg1_q  <= out_arg1_d;
            out_arg2_q  <= out_arg2_d;
            out_ext_q   <= out_ext_d;
            out_pc_q    <= out_pc_d;
            held_word_q <= held_word_d;
            held_pc_q   <= held_pc_d;
`ifdef AVR_DECODE_ILLEGAL_EN
            out_illegal_q <= out_illegal_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_id    = out_id_q;
    assign out_arg1  = out_arg1_q;
    assign out_arg2  = out_arg2_q;
    assign out_ext   = out_ext_q;
    assign out_pc    = out_pc_q;
`ifdef AVR_DECODE_ILLEGAL_EN
    assign out_illegal = out_illegal_q;
`endif

endmodule

// File: tb/tb_avr_decode_stage.sv
// Bench for avr_decode_stage: directed table, hand sequences and random traffic
// against a mask/match instruction-table model with a packet queue.
module tb_avr_decode_stage;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
    logic [15:0] in_word, in_pc, out_ext, out_pc;
    logic [7:0]  out_id, out_arg1, out_arg2;
`ifdef AVR_DECODE_ILLEGAL_EN
    logic        out_illegal;
`endif

    always #5 clk = ~clk;

    avr_decode_stage #(.PC_WIDTH(16), .ID_WIDTH(8), .ARG_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_arg1(out_arg1), .out_arg2(out_arg2), .out_ext(out_ext), .out_pc(out_pc)
`ifdef AVR_DECODE_ILLEGAL_EN
        , .out_illegal(out_illegal)
`endif
    );

    localparam int F_NONE = 0, F_RR = 1, F_IMM = 2, F_R1 = 3, F_R0 = 4, F_IO = 5,
                   F_BR = 6, F_REL = 7, F_LONG = 8, F_MEM = 9;

    typedef struct { logic [15:0] mask; logic [15:0] match; logic [7:0] id; int form; } pat_t;
    typedef struct { logic [7:0] id; logic [7:0] a1; logic [7:0] a2; logic [15:0] ext; logic [15:0] pc; logic ill; } pkt_t;
    typedef struct { logic [15:0] w; logic [7:0] id; logic [7:0] a1; logic [7:0] a2; logic ill; } vec_t;

    pat_t        pats[$];
    pkt_t        exp_q[$];
    bit          pend;
    logic [15:0] pend_word, pend_pc;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic add_pat(input logic [15:0] mask, input logic [15:0] match, input logic [7:0] id, input int form);
        pat_t p;
        p.mask = mask; p.match = match; p.id = id; p.form = form;
        pats.push_back(p);
    endtask

    function automatic int find_pat(input logic [15:0] w);
        for (int i = 0; i < pats.size(); i++)
            if ((w & pats[i].mask) == pats[i].match) return i;
        return -1;
    endfunction

    function automatic pkt_t model(input logic [15:0] w, input logic [15:0] ext, input logic [15:0] pc);
        pkt_t p;
        int   idx;
        int   k;
        idx = find_pat(w);
        p.id = 8'h00; p.a1 = 8'h00; p.a2 = 8'h00; p.ext = 16'h0000; p.pc = pc;
        p.ill = (idx < 0) && (w != 16'h0000);
        if (idx >= 0) begin
            p.id = pats[idx].id;
            case (pats[idx].form)
                F_RR:   begin p.a1 = 8'(int'(w[8:4])); p.a2 = 8'(int'(w[9]) * 16 + int'(w[3:0])); end
                F_IMM:  begin p.a1 = 8'(16 + int'(w[7:4])); p.a2 = 8'(int'(w[11:8]) * 16 + int'(w[3:0])); end
                F_R1:   begin p.a1 = 8'(int'(w[8:4])); p.a2 = 8'd1; end
                F_R0:   p.a1 = 8'(int'(w[8:4]));
                F_IO:   begin p.a1 = 8'(int'(w[8:4])); p.a2 = 8'(int'(w[10:9]) * 16 + int'(w[3:0])); end
                F_BR:   begin k = int'(w[9:3]); if (k > 63) k = k - 128; p.a1 = 8'(k); end
                F_REL:  begin p.a1 = 8'(int'(w[7:0])); p.a2 = 8'(int'(w[11:8])); end
                F_LONG: begin p.a1 = 8'(int'(w[8:4]) * 2 + int'(w[0])); p.ext = ext; end
                F_MEM:  begin p.a1 = 8'(int'(w[8:4])); p.ext = ext; end
                default: p.a1 = 8'h00;
            endcase
        end
        return p;
    endfunction

    function automatic bit is_two(input logic [15:0] w);
        int idx;
        idx = find_pat(w);
        return (idx >= 0) && (pats[idx].form == F_LONG || pats[idx].form == F_MEM);
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive, check DUT against model state, advance model, step past edge.
    task automatic cycle(input bit rst, input bit fl, input bit v, input logic [15:0] w,
                         input logic [15:0] pc, input bit rdy);
        bit exp_ready;
        reset = rst; flush = fl; in_valid = v; in_word = w; in_pc = pc; out_ready = rdy;
        #1;
        exp_ready = !fl && (exp_q.size() == 0 || rdy);
        cmp("in_ready", 32'(in_ready), 32'(exp_ready));
        cmp("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            cmp("out_id", 32'(out_id), 32'(exp_q[0].id));
            cmp("out_arg1", 32'(out_arg1), 32'(exp_q[0].a1));
            cmp("out_arg2", 32'(out_arg2), 32'(exp_q[0].a2));
            cmp("out_ext", 32'(out_ext), 32'(exp_q[0].ext));
            cmp("out_pc", 32'(out_pc), 32'(exp_q[0].pc));
`ifdef AVR_DECODE_ILLEGAL_EN
            cmp("out_illegal", 32'(out_illegal), 32'(exp_q[0].ill));
`endif
        end
        if (rst || fl) begin
            exp_q.delete();
            pend = 1'b0;
        end else begin
            if (rdy && exp_q.size() != 0) void'(exp_q.pop_front());
            if (v && exp_ready) begin
                if (pend) begin
                    exp_q.push_back(model(pend_word, w, pend_pc));
                    pend = 1'b0;
                end else if (is_two(w)) begin
                    pend = 1'b1; pend_word = w; pend_pc = pc;
                end else begin
                    exp_q.push_back(model(w, 16'h0000, pc));
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    vec_t        vecs[$];
    logic [15:0] pc_r;
    logic [15:0] rw;

    task automatic add_vec(input logic [15:0] w, input logic [7:0] id, input logic [7:0] a1,
                           input logic [7:0] a2, input logic ill);
        vec_t v;
        v.w = w; v.id = id; v.a1 = a1; v.a2 = a2; v.ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        add_pat(16'hFFFF, 16'h0000, 8'h00, F_NONE);
        add_pat(16'hFC00, 16'h1C00, 8'h01, F_RR);   add_pat(16'hFC00, 16'h0C00, 8'h02, F_RR);
        add_pat(16'hFC00, 16'h2000, 8'h03, F_RR);   add_pat(16'hFC00, 16'h1400, 8'h0C, F_RR);
        add_pat(16'hFC00, 16'h1000, 8'h0E, F_RR);   add_pat(16'hFC00, 16'h2400, 8'h10, F_RR);
        add_pat(16'hFC00, 16'h2C00, 8'h25, F_RR);   add_pat(16'hFC00, 16'h9C00, 8'h26, F_RR);
        add_pat(16'hFC00, 16'h2800, 8'h27, F_RR);   add_pat(16'hFC00, 16'h1800, 8'h40, F_RR);
        add_pat(16'hF000, 16'h3000, 8'h0D, F_IMM);  add_pat(16'hF000, 16'hE000, 8'h20, F_IMM);
        add_pat(16'hF000, 16'h6000, 8'h28, F_IMM);  add_pat(16'hF000, 16'h5000, 8'h41, F_IMM);
        add_pat(16'hFC07, 16'hF400, 8'h04, F_BR);   add_pat(16'hFC07, 16'hF000, 8'h05, F_BR);
        add_pat(16'hFC07, 16'hF001, 8'h06, F_BR);   add_pat(16'hFC07, 16'hF401, 8'h08, F_BR);
        add_pat(16'hFE0E, 16'h940E, 8'h09, F_LONG); add_pat(16'hFE0E, 16'h940C, 8'h13, F_LONG);
        add_pat(16'hFE0F, 16'h9000, 8'h21, F_MEM);  add_pat(16'hFE0F, 16'h9200, 8'h3F, F_MEM);
        add_pat(16'hFE0F, 16'h940A, 8'h0F, F_R1);   add_pat(16'hFE0F, 16'h9403, 8'h12, F_R1);
        add_pat(16'hFE0F, 16'h900F, 8'h2A, F_R1);   add_pat(16'hFE0F, 16'h920F, 8'h2B, F_R1);
        add_pat(16'hFE0F, 16'h9406, 8'h24, F_R0);   add_pat(16'hFE0F, 16'h9407, 8'h31, F_R0);
        add_pat(16'hF800, 16'hB000, 8'h11, F_IO);   add_pat(16'hF800, 16'hB800, 8'h29, F_IO);
        add_pat(16'hF000, 16'hD000, 8'h2C, F_REL);  add_pat(16'hF000, 16'hC000, 8'h2F, F_REL);
        add_pat(16'hFFFF, 16'h94F8, 8'h0A, F_NONE); add_pat(16'hFFFF, 16'h9478, 8'h32, F_NONE);
        add_pat(16'hFFFF, 16'h9508, 8'h2D, F_NONE); add_pat(16'hFFFF, 16'h9518, 8'h2E, F_NONE);

        // Hand-derived single-word decodes.
        add_vec(16'h0C12, 8'h02, 8'h01, 8'h02, 1'b0);  add_vec(16'hEF0F, 8'h20, 8'h10, 8'hFF, 1'b0);
        add_vec(16'h2C01, 8'h25, 8'h00, 8'h01, 1'b0);  add_vec(16'h95F3, 8'h12, 8'h1F, 8'h01, 1'b0);
        add_vec(16'hF3F9, 8'h06, 8'hFF, 8'h00, 1'b0);  add_vec(16'hF408, 8'h04, 8'h01, 8'h00, 1'b0);
        add_vec(16'hB7CF, 8'h11, 8'h1C, 8'h3F, 1'b0);  add_vec(16'hBE05, 8'h29, 8'h00, 8'h35, 1'b0);
        add_vec(16'hDFFF, 8'h2C, 8'hFF, 8'h0F, 1'b0);  add_vec(16'hC123, 8'h2F, 8'h23, 8'h01, 1'b0);
        add_vec(16'h9508, 8'h2D, 8'h00, 8'h00, 1'b0);  add_vec(16'h94F8, 8'h0A, 8'h00, 8'h00, 1'b0);
        add_vec(16'h9478, 8'h32, 8'h00, 8'h00, 1'b0);  add_vec(16'h9518, 8'h2E, 8'h00, 8'h00, 1'b0);
        add_vec(16'h5A3C, 8'h41, 8'h13, 8'hAC, 1'b0);  add_vec(16'h93FF, 8'h2B, 8'h1F, 8'h01, 1'b0);
        add_vec(16'h9C45, 8'h26, 8'h04, 8'h05, 1'b0);  add_vec(16'h95E7, 8'h31, 8'h1E, 8'h00, 1'b0);
        add_vec(16'h0000, 8'h00, 8'h00, 8'h00, 1'b0);  add_vec(16'hFFFF, 8'h00, 8'h00, 8'h00, 1'b1);
        add_vec(16'h0180, 8'h00, 8'h00, 8'h00, 1'b1);

        pend = 1'b0;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_word = 16'h0000; in_pc = 16'h0000; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cmp("rst_valid", 32'(out_valid), 32'd0);
        cmp("rst_id", 32'(out_id), 32'd0);
        cmp("rst_arg1", 32'(out_arg1), 32'd0);
        cmp("rst_arg2", 32'(out_arg2), 32'd0);
        cmp("rst_ext", 32'(out_ext), 32'd0);
        cmp("rst_pc", 32'(out_pc), 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(1'b0, 1'b0, 1'b1, vecs[i].w, 16'(16 + i), 1'b1);
            cmp("tbl_valid", 32'(out_valid), 32'd1);
            cmp("tbl_id", 32'(out_id), 32'(vecs[i].id));
            cmp("tbl_arg1", 32'(out_arg1), 32'(vecs[i].a1));
            cmp("tbl_arg2", 32'(out_arg2), 32'(vecs[i].a2));
            cmp("tbl_ext", 32'(out_ext), 32'd0);
            cmp("tbl_pc", 32'(out_pc), 32'(16 + i));
`ifdef AVR_DECODE_ILLEGAL_EN
            cmp("tbl_illegal", 32'(out_illegal), 32'(vecs[i].ill));
`endif
        end

        // JMP 0x0100 split over two words.
        cycle(1'b0, 1'b0, 1'b1, 16'h940C, 16'h0020, 1'b1);
        cmp("jmp_first_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0100, 16'h0021, 1'b1);
        cmp("jmp_valid", 32'(out_valid), 32'd1);
        cmp("jmp_id", 32'(out_id), 32'h13);
        cmp("jmp_arg1", 32'(out_arg1), 32'h00);
        cmp("jmp_ext", 32'(out_ext), 32'h0100);
        cmp("jmp_pc", 32'(out_pc), 32'h0020);

        // Backpressure: packet held while a second word waits.
        cycle(1'b0, 1'b0, 1'b1, 16'h0C12, 16'h0030, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 1'b1, 16'h2C01, 16'h0031, 1'b0);
        cmp("stall_id", 32'(out_id), 32'h02);
        cmp("stall_pc", 32'(out_pc), 32'h0030);
        cycle(1'b0, 1'b0, 1'b1, 16'h2C01, 16'h0031, 1'b1);
        cmp("release_id", 32'(out_id), 32'h25);
        cmp("release_pc", 32'(out_pc), 32'h0031);

        // Flush while waiting for the LDS operand.
        cycle(1'b0, 1'b0, 1'b1, 16'h9100, 16'h0040, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 16'h1234, 16'h0041, 1'b1);
        cmp("flush_valid", 32'(out_valid), 32'd0);
        cycle(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0042, 1'b1);
        cmp("flush_nop_id", 32'(out_id), 32'h00);
        cmp("flush_nop_ext", 32'(out_ext), 32'h0000);
        cmp("flush_nop_pc", 32'(out_pc), 32'h0042);

        // Reset during WAIT2: next word is an opcode again.
        cycle(1'b0, 1'b0, 1'b1, 16'h9200, 16'h0050, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 16'h0C12, 16'h0051, 1'b1);
        cmp("rst_wait2_id", 32'(out_id), 32'h02);
        cmp("rst_wait2_pc", 32'(out_pc), 32'h0051);

        // Random traffic biased toward listed encodings.
        pc_r = 16'h0100;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                rw = 16'($urandom);
            end else begin
                int idx;
                idx = $urandom_range(0, pats.size() - 1);
                rw = pats[idx].match | (16'($urandom) & ~pats[idx].mask);
            end
            pc_r = pc_r + 16'd1;
            cycle(1'b0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0, rw, pc_r,
                  $urandom_range(0, 9) < 7);
        end
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
